addi_pipe: RTL and testbench
============================

ADDI_PIPE -- requirements
Module: addi_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, which is the operand/result width and must be even.
REQ-002 SHALL have parameter IMM_WIDTH, default 16, which is the immediate width, with 2 <= IMM_WIDTH <= WIDTH.
REQ-003 SHALL have parameter CNT_WIDTH, default 8, which is the width of the overflow event counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 in_valid  input  1  the input operation is valid.
REQ-007 in_ready  output  1  the unit accepts an input this cycle.
REQ-008 a  input  WIDTH  register operand.
REQ-009 imm  input  IMM_WIDTH  immediate operand.
REQ-010 mode  input  2  operation: 00 addi, 01 addiu, 10 subi, 11 addi_sat.
REQ-011 out_valid  output  1  the result is valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum  output  WIDTH  result.
REQ-014 carry  output  1  raw carry-out of the full-width adder.
REQ-015 overflow  output  1  mode-specific overflow flag.
REQ-016 clr_count  input  1  synchronous clear of ovf_count.
REQ-017 ovf_count  output  CNT_WIDTH  saturating count of delivered results with overflow=1.

Function
REQ-018 Immediate extension SHALL be sign-extension for modes 00, 10 and 11, and zero-extension for mode 01.
REQ-019 Results SHALL be computed as: addi/addiu/addi_sat a + ext(imm); subi a + ~ext(imm) + 1; all mod 2^WIDTH.
REQ-020 Overflow SHALL be: addi/addi_sat when the operand signs are equal and the result sign differs; subi when the signs of a and ext(imm) differ and the result sign differs from a; addiu equal to carry.
REQ-021 addi_sat on overflow SHALL clamp sum to 0x7F..F when a is non-negative, else 0x80..0; overflow remains 1 and carry is unaffected by the clamp.
REQ-022 Stage 1 SHALL compute the low WIDTH/2 bits and their carry, and register the low sum, the carry, the upper halves of a and ext(imm), and mode.
REQ-023 Stage 2 SHALL compute the upper half from the registered carry, derive the flags and saturation, and register the outputs.
REQ-024 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready stays high; throughput SHALL be 1 result per cycle.
REQ-025 Advance SHALL be defined as adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally.
REQ-026 Input SHALL be accepted only when in_valid && in_ready; when adv=0 both stages hold all state, including valid bits.
REQ-027 When adv=1, stage valids SHALL shift: s1_valid <= in_valid, out_valid <= s1_valid, so bubbles propagate.
REQ-028 sum, carry and overflow SHALL remain stable while out_valid && !out_ready.
REQ-029 Results SHALL emerge in acceptance order with no loss or duplication under any out_ready pattern.
REQ-030 ovf_count SHALL increment when out_valid && out_ready && overflow, and hold at 2^CNT_WIDTH-1.
REQ-031 When clr_count is asserted together with an increment, clear SHALL win and ovf_count becomes 0.
REQ-032 Outputs while out_valid=0 SHALL be don't-care to the consumer, but SHALL NOT be X after reset.

Reset
REQ-033 rst=1 SHALL asynchronously force s1_valid=0, out_valid=0, sum=0, carry=0, overflow=0, ovf_count=0 and all pipeline registers to 0.
REQ-034 in_ready SHALL be 1 during and after reset, since out_valid=0.
REQ-035 rst asserted mid-operation SHALL discard all in-flight operations, and no result for them SHALL appear after release.
REQ-036 The first input accepted on the cycle after rst deasserts SHALL produce out_valid two cycles later.

Verification (WIDTH=32, IMM_WIDTH=16, out_ready=1 unless stated)
REQ-037 Bench SHALL cover addi with a=0x7FFFFFFF, imm=0x1000 -> sum=0x80000FFF, overflow=1, carry=0; the same input in mode 11 -> sum=0x7FFFFFFF, overflow=1.
REQ-038 Bench SHALL cover a=0xFFFFFDF8, imm=0x904A: mode 00 -> sum=0xFFFF8E42, carry=1, overflow=0; mode 01 -> sum=0x00008E42, carry=1, overflow=1.
REQ-039 Bench SHALL cover subi with a=0x80000000, imm=0x0001 -> sum=0x7FFFFFFF, overflow=1; a=0x00000005, imm=0x0005 -> sum=0, carry=1, overflow=0.
REQ-040 Bench SHALL cover backpressure: push 3 ops back-to-back, hold out_ready=0 for 4 cycles -> in_ready=0 and outputs frozen on op1; release -> op1, op2, op3 delivered on consecutive cycles.
REQ-041 Bench SHALL cover the counter: 256 overflowing deliveries with CNT_WIDTH=8 -> ovf_count=255; clr_count held together with an overflowing delivery -> ovf_count=0.
REQ-042 Bench SHALL cover reset: assert rst with 2 ops in flight -> out_valid=0 immediately and no stale result after release; the next op produces out_valid at exactly +2 cycles.

Source files
------------

// File: rtl/addi_pipe.sv
// Two-stage add-immediate unit: stage 1 adds the low half, stage 2 adds the upper half
// and derives flags/saturation. Valid/ready handshake, plus a saturating overflow counter.
module addi_pipe #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     sum,
  output logic                 carry,
  output logic                 overflow,
  input  logic                 clr_count,
  output logic [CNT_WIDTH-1:0] ovf_count
);

  localparam int HALF = WIDTH / 2;
  localparam logic [1:0] MODE_ADDIU = 2'b01;
  localparam logic [1:0] MODE_SUBI  = 2'b10;
  localparam logic [1:0] MODE_SAT   = 2'b11;

  logic                 w_adv;
  logic [WIDTH-1:0]     w_ext;
  logic                 w_sub1;
  logic [HALF-1:0]      w_b_lo;
  logic [HALF:0]        w_lo_full;

  logic                 r1_valid;
  logic [HALF-1:0]      r1_lo;
  logic                 r1_c;
  logic [HALF-1:0]      r1_a_hi;
  logic [HALF-1:0]      r1_ext_hi;
  logic [1:0]           r1_mode;

  logic                 w_sub2;
  logic [HALF-1:0]      w_b_hi;
  logic [HALF:0]        w_hi_full;
  logic [WIDTH-1:0]     w_res;
  logic                 w_carry;
  logic                 w_ovf;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_a_s;
  logic                 w_e_s;
  logic                 w_r_s;

  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_sum;
  logic                 r_carry;
  logic                 r_overflow;
  logic [CNT_WIDTH-1:0] r_cnt;

  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  // Subtraction is done as a + ~ext + 1; the +1 enters as the low-half carry-in.
  assign w_ext     = (mode == MODE_ADDIU) ? WIDTH'(imm) : WIDTH'($signed(imm));
  assign w_sub1    = (mode == MODE_SUBI);
  assign w_b_lo    = w_sub1 ? ~w_ext[HALF-1:0] : w_ext[HALF-1:0];
  assign w_lo_full = {1'b0, a[HALF-1:0]} + {1'b0, w_b_lo} + (HALF+1)'(w_sub1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid  <= 1'b0;
      r1_lo     <= '0;
      r1_c      <= 1'b0;
      r1_a_hi   <= '0;
      r1_ext_hi <= '0;
      r1_mode   <= '0;
    end else if (w_adv) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_lo     <= w_lo_full[HALF-1:0];
        r1_c      <= w_lo_full[HALF];
        r1_a_hi   <= a[WIDTH-1:HALF];
        r1_ext_hi <= w_ext[WIDTH-1:HALF];
        r1_mode   <= mode;
      end
    end
  end

  assign w_sub2    = (r1_mode == MODE_SUBI);
  assign w_b_hi    = w_sub2 ? ~r1_ext_hi : r1_ext_hi;
  assign w_hi_full = {1'b0, r1_a_hi} + {1'b0, w_b_hi} + (HALF+1)'(r1_c);
  assign w_res     = {w_hi_full[HALF-1:0], r1_lo};
  assign w_carry   = w_hi_full[HALF];
  assign w_a_s     = r1_a_hi[HALF-1];
  assign w_e_s     = r1_ext_hi[HALF-1];
  assign w_r_s     = w_res[WIDTH-1];

  always_comb begin
    w_ovf = 1'b0;
    case (r1_mode)
      MODE_ADDIU: w_ovf = w_carry;
      MODE_SUBI:  w_ovf = (w_a_s != w_e_s) && (w_r_s != w_a_s);
      default:    w_ovf = (w_a_s == w_e_s) && (w_r_s != w_a_s);
    endcase
  end

  always_comb begin
    w_sum = w_res;
    if (r1_mode == MODE_SAT && w_ovf)
      w_sum = w_a_s ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r1_valid;
      if (r1_valid) begin
        r_sum      <= w_sum;
        r_carry    <= w_carry;
        r_overflow <= w_ovf;
      end
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (clr_count)
      r_cnt <= '0;
    else if (r_out_valid && out_ready && r_overflow && (r_cnt != {CNT_WIDTH{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign ovf_count = r_cnt;

endmodule

// File: tb/tb_addi_pipe.sv
// Self-checking bench for addi_pipe: directed corner vectors, backpressure, counter and
// reset scenarios, then randomized traffic checked against an arithmetic reference model.
module tb_addi_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [15:0] imm;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        carry;
  logic        overflow;
  logic        clr_count;
  logic [7:0]  ovf_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q[$];
  int   mcnt = 0;
  logic stalled = 1'b0;

  addi_pipe #(.WIDTH(32), .IMM_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .imm(imm), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .overflow(overflow),
    .clr_count(clr_count), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: true signed result range decides overflow; plain 33-bit add gives carry.
  function automatic exp_t model(input logic [31:0] ma, input logic [15:0] mi, input logic [1:0] mm);
    exp_t r;
    longint sa, se, st;
    logic [32:0] full;
    logic [31:0] ext;
    ext = (mm == 2'b01) ? {16'h0, mi} : {{16{mi[15]}}, mi};
    sa = longint'($signed(ma));
    se = longint'($signed(ext));
    if (mm == 2'b10) begin
      full = {1'b0, ma} + {1'b0, ~ext} + 33'd1;
      st = sa - se;
    end else begin
      full = {1'b0, ma} + {1'b0, ext};
      st = sa + se;
    end
    r.sum = full[31:0];
    r.c   = full[32];
    if (mm == 2'b01) r.o = r.c;
    else r.o = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    if (mm == 2'b11 && r.o) r.sum = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return r;
  endfunction

  // Monitor: acceptance order scoreboard, handshake and counter model, evaluated mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mcnt = 0;
      stalled = 1'b0;
      chk("reset out_valid", out_valid, 0);
      chk("reset in_ready", in_ready, 1);
      chk("reset ovf_count", ovf_count, 0);
      chk("reset outputs", {sum, carry, overflow}, 0);
    end else begin
      exp_t e;
      logic deliv;
      logic e_ovf;
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (stalled) chk("held out_valid", out_valid, 1);
      deliv = out_valid && out_ready;
      e_ovf = 1'b0;
      if (deliv) begin
        if (q.size() == 0) begin
          chk("stale result", 1, 0);
        end else begin
          e = q.pop_front();
          e_ovf = e.o;
          chk("sum", sum, e.sum);
          chk("carry", carry, e.c);
          chk("overflow", overflow, e.o);
        end
      end
      chk("ovf_count", ovf_count, mcnt);
      if (clr_count) mcnt = 0;
      else if (deliv && e_ovf && mcnt < 255) mcnt++;
      if (in_valid && in_ready) q.push_back(model(a, imm, mode));
      stalled = out_valid && !out_ready;
    end
  end

  task automatic run_op(input logic [31:0] ta, input logic [15:0] ti, input logic [1:0] tm,
                        input logic [31:0] es, input logic ec, input logic eo,
                        input string nm, input bit now);
    int lat;
    if (!now) begin
      @(posedge clk); #1;
    end
    a = ta; imm = ti; mode = tm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, 2);
    chk({nm, " sum"}, sum, es);
    chk({nm, " carry"}, carry, ec);
    chk({nm, " overflow"}, overflow, eo);
  endtask

  task automatic check_model(input logic [31:0] ta, input logic [15:0] ti, input logic [1:0] tm,
                             input logic [31:0] es, input logic ec, input logic eo, input string nm);
    exp_t r;
    r = model(ta, ti, tm);
    chk({nm, " model"}, {r.sum, r.c, r.o}, {es, ec, eo});
  endtask

  exp_t bp[3];
  logic [31:0] ra;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; imm = '0; mode = '0;
    out_ready = 1'b1; clr_count = 1'b0;
    #1;
    chk("in_ready during reset", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_model(32'h7FFF_FFFF, 16'h1000, 2'b00, 32'h8000_0FFF, 1'b0, 1'b1, "addi ovf");
    check_model(32'h7FFF_FFFF, 16'h1000, 2'b11, 32'h7FFF_FFFF, 1'b0, 1'b1, "sat ovf");
    check_model(32'hFFFF_FDF8, 16'h904A, 2'b00, 32'hFFFF_8E42, 1'b1, 1'b0, "addi neg");
    check_model(32'hFFFF_FDF8, 16'h904A, 2'b01, 32'h0000_8E42, 1'b1, 1'b1, "addiu");
    check_model(32'h8000_0000, 16'h0001, 2'b10, 32'h7FFF_FFFF, 1'b1, 1'b1, "subi ovf");
    check_model(32'h0000_0005, 16'h0005, 2'b10, 32'h0000_0000, 1'b1, 1'b0, "subi zero");

    run_op(32'h7FFF_FFFF, 16'h1000, 2'b00, 32'h8000_0FFF, 1'b0, 1'b1, "addi ovf", 0);
    run_op(32'h7FFF_FFFF, 16'h1000, 2'b11, 32'h7FFF_FFFF, 1'b0, 1'b1, "sat ovf", 0);
    run_op(32'hFFFF_FDF8, 16'h904A, 2'b00, 32'hFFFF_8E42, 1'b1, 1'b0, "addi neg", 0);
    run_op(32'hFFFF_FDF8, 16'h904A, 2'b01, 32'h0000_8E42, 1'b1, 1'b1, "addiu", 0);
    run_op(32'h8000_0000, 16'h0001, 2'b10, 32'h7FFF_FFFF, 1'b1, 1'b1, "subi ovf", 0);
    run_op(32'h0000_0005, 16'h0005, 2'b10, 32'h0000_0000, 1'b1, 1'b0, "subi zero", 0);
    run_op(32'h8000_0000, 16'hFFFF, 2'b11, 32'h8000_0000, 1'b1, 1'b1, "sat neg", 0);

    // Backpressure: three ops back-to-back, consumer stalls once op1 reaches the output.
    bp[0] = model(32'h0000_0010, 16'h0001, 2'b00);
    bp[1] = model(32'h0000_0020, 16'h0002, 2'b01);
    bp[2] = model(32'h0000_0030, 16'h0003, 2'b10);
    @(posedge clk); #1;
    a = 32'h10; imm = 16'h1; mode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h20; imm = 16'h2; mode = 2'b01;
    @(posedge clk); #1;
    a = 32'h30; imm = 16'h3; mode = 2'b10; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp in_ready", in_ready, 0);
      chk("bp frozen", {out_valid, sum, carry, overflow}, {1'b1, bp[0].sum, bp[0].c, bp[0].o});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp release", {out_valid, sum}, {1'b1, bp[i].sum});
      @(posedge clk); #1;
      in_valid = 1'b0;
    end

    // Counter saturation, then clear versus simultaneous increment.
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    a = 32'hFFFF_FFFF; imm = 16'h0001; mode = 2'b01; in_valid = 1'b1;
    repeat (256) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("ovf_count saturated", ovf_count, 255);
    run_op(32'hFFFF_FFFF, 16'h0001, 2'b01, 32'h0, 1'b1, 1'b1, "cnt op", 0);
    repeat (2) @(posedge clk);
    #1 clr_count = 1'b1;
    @(posedge clk); #1 clr_count = 1'b0;
    chk("ovf_count cleared", ovf_count, 0);
    run_op(32'hFFFF_FFFF, 16'h0001, 2'b01, 32'h0, 1'b1, 1'b1, "cnt one", 0);
    @(posedge clk); #1;
    chk("ovf_count one", ovf_count, 1);
    a = 32'hFFFF_FFFF; imm = 16'h0001; mode = 2'b01; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 clr_count = 1'b1;
    chk("clr with delivery valid", out_valid && overflow, 1);
    @(posedge clk); #1 clr_count = 1'b0;
    chk("clr beats increment", ovf_count, 0);

    // Reset with two operations in flight.
    a = 32'h1; imm = 16'h1; mode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1 chk("rst out_valid immediate", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_op(32'h0000_1234, 16'hFFFF, 2'b00, 32'h0000_1233, 1'b1, 1'b0, "post reset", 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      case ($urandom_range(0, 5))
        0: ra = 32'h7FFF_FFFF;
        1: ra = 32'h8000_0000;
        2: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      a         = ra;
      imm       = 16'($urandom);
      mode      = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      clr_count = ($urandom_range(0, 31) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("queue drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
